// File: rtl/alsu_seg_display.sv
// ---------------------------------------------------------------------------
// alsu_seg_display
//
// Output stage for the 3-bit ALSU. The 6-bit ALSU result and its error
// indication are registered, the result is converted to two BCD digits by a
// sequential double-dabble FSM, and the digits are shown on a 4-digit,
// multiplexed, active-low 7-segment display. A sticky error latch replaces
// the number with "-Er-" until it is cleared.
//
// Ports
//   clk_i      single clock, rising edge
//   rst_i      asynchronous, active-high reset
//   result_i   ALSU result, unsigned 0..63
//   err_in_i   OR of the ALSU LEDs (invalid-operation indication)
//   err_clr_i  clears the error latch (ignored while an error is present)
//   an_o       anode enables, active-low, one-hot-low
//   seg_o      segments {g,f,e,d,c,b,a}, active-low
//   dp_o       decimal point, active-low, always off
//   busy_o     high while a conversion is in progress
//   done_o     one-cycle pulse when new BCD digits are loaded
// ---------------------------------------------------------------------------
module alsu_seg_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] result_i,
  input  logic       err_in_i,
  input  logic       err_clr_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_R     = 7'b0101111;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_e;

  state_e state_q, state_d;

  logic [5:0] result_q;
  logic       errIn_q;
  logic       errLatch_q;

  logic [5:0] convVal_q, convVal_d;
  logic [5:0] shiftReg_q, shiftReg_d;
  logic [7:0] bcd_q, bcd_d;
  logic [2:0] step_q, step_d;
  logic [5:0] lastVal_q, lastVal_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       done_q, done_d;

  logic [7:0]  adjusted;
  logic [13:0] shifted;

  logic [CNT_W-1:0] refreshCnt_q;
  logic [1:0]       digitIdx_q;
  logic [6:0]       glyph;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;

  function automatic logic [6:0] digitGlyph(input logic [3:0] digit);
    logic [6:0] g;
    case (digit)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // Input stage: the ALSU outputs are captured every edge so the rest of the
  // block only ever sees registered values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q <= '0;
      errIn_q  <= 1'b0;
    end else begin
      result_q <= result_i;
      errIn_q  <= err_in_i;
    end
  end

  // Sticky error latch. A pending error always beats a clear request, so a
  // clear only takes effect once the registered error indication is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      errLatch_q <= 1'b0;
    end else if (errIn_q) begin
      errLatch_q <= 1'b1;
    end else if (err_clr_i) begin
      errLatch_q <= 1'b0;
    end
  end

  // Double-dabble conversion FSM. The converted value is kept separately
  // from the shift register because the shift register is emptied by the
  // time LOAD records which value is now on display.
  always_comb begin
    state_d    = state_q;
    convVal_d  = convVal_q;
    shiftReg_d = shiftReg_q;
    bcd_d      = bcd_q;
    step_d     = step_q;
    lastVal_d  = lastVal_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    done_d     = 1'b0;

    adjusted = bcd_q;
    if (bcd_q[3:0] >= 4'd5) begin
      adjusted[3:0] = bcd_q[3:0] + 4'd3;
    end
    if (bcd_q[7:4] >= 4'd5) begin
      adjusted[7:4] = bcd_q[7:4] + 4'd3;
    end
    shifted = {adjusted, shiftReg_q} << 1;

    case (state_q)
      IDLE: begin
        if (result_q != lastVal_q) begin
          state_d    = CONV;
          convVal_d  = result_q;
          shiftReg_d = result_q;
          bcd_d      = '0;
          step_d     = '0;
        end
      end
      CONV: begin
        bcd_d      = shifted[13:6];
        shiftReg_d = shifted[5:0];
        step_d     = step_q + 3'd1;
        if (step_q == 3'd5) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        ones_d    = bcd_q[3:0];
        tens_d    = bcd_q[7:4];
        lastVal_d = convVal_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and conversion datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      convVal_q  <= '0;
      shiftReg_q <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      lastVal_q  <= '0;
      ones_q     <= '0;
      tens_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      convVal_q  <= convVal_d;
      shiftReg_q <= shiftReg_d;
      bcd_q      <= bcd_d;
      step_q     <= step_d;
      lastVal_q  <= lastVal_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      done_q     <= done_d;
    end
  end

  // Refresh timer: each digit stays lit for REFRESH_DIV cycles and the
  // two-bit index wraps 3->0 naturally with no gap cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      refreshCnt_q <= '0;
      digitIdx_q   <= '0;
    end else if (refreshCnt_q == CNT_LAST) begin
      refreshCnt_q <= '0;
      digitIdx_q   <= digitIdx_q + 2'd1;
    end else begin
      refreshCnt_q <= refreshCnt_q + CNT_W'(1);
    end
  end

  // Glyph for the digit position currently selected. In error mode the
  // display reads "-Er-" from the left; otherwise only the two low digits
  // show the number, with a leading zero suppressed in the tens position.
  always_comb begin
    glyph = GLYPH_BLANK;
    if (errLatch_q) begin
      case (digitIdx_q)
        2'd0:    glyph = GLYPH_DASH;
        2'd1:    glyph = GLYPH_R;
        2'd2:    glyph = GLYPH_E;
        default: glyph = GLYPH_DASH;
      endcase
    end else begin
      case (digitIdx_q)
        2'd0:    glyph = digitGlyph(ones_q);
        2'd1:    glyph = (tens_q == 4'd0) ? GLYPH_BLANK : digitGlyph(tens_q);
        default: glyph = GLYPH_BLANK;
      endcase
    end
  end

  // Display drivers are registered so anode and segment lines switch on
  // the same edge and never glitch between digits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      an_q  <= 4'b1111;
      seg_q <= GLYPH_BLANK;
    end else begin
      an_q  <= ~(4'b0001 << digitIdx_q);
      seg_q <= glyph;
    end
  end

  assign an_o   = an_q;
  assign seg_o  = seg_q;
  assign dp_o   = 1'b1;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_alsu_seg_display.sv
// ---------------------------------------------------------------------------
// tb_alsu_seg_display
//
// Self-checking bench for alsu_seg_display with REFRESH_DIV = 4. A
// behavioural model built from decimal arithmetic (value % 10, value / 10),
// a glyph lookup table and a cycle countdown predicts every output each
// cycle; directed steps add explicit checks for the documented scenarios.
// ---------------------------------------------------------------------------
module tb_alsu_seg_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] result;
  logic       errIn;
  logic       errClr;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int mCap, mErrCap, mLatch, mLast, mSnap, mLeft, mOnes, mTens, mIdx, mCnt;
  logic       mDone;
  logic [3:0] eAn;
  logic [6:0] eSeg;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] GE    = 7'b0000110;
  localparam logic [6:0] GR    = 7'b0101111;

  logic [6:0] digitTable [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  alsu_seg_display #(.REFRESH_DIV(DIV)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .result_i  (result),
    .err_in_i  (errIn),
    .err_clr_i (errClr),
    .an_o      (an),
    .seg_o     (seg),
    .dp_o      (dp),
    .busy_o    (busy),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  // Everything returns to its documented reset value.
  task automatic modelReset();
    mCap = 0; mErrCap = 0; mLatch = 0; mLast = 0; mSnap = 0;
    mLeft = 0; mOnes = 0; mTens = 0; mIdx = 0; mCnt = 0;
    mDone = 1'b0;
    eAn = 4'b1111;
    eSeg = BLANK;
  endtask

  // What the display should show at a given position from the model state.
  function automatic logic [6:0] modelGlyph(input int idx);
    if (mLatch != 0) begin
      if (idx == 1) return GR;
      if (idx == 2) return GE;
      return DASH;
    end
    if (idx == 0) return digitTable[mOnes];
    if (idx == 1) return (mTens == 0) ? BLANK : digitTable[mTens];
    return BLANK;
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic modelStep();
    eAn  = ~(4'b0001 << mIdx);
    eSeg = modelGlyph(mIdx);
    mCnt = mCnt + 1;
    if (mCnt == DIV) begin
      mCnt = 0;
      mIdx = (mIdx + 1) % 4;
    end
    mDone = 1'b0;
    if (mLeft == 0) begin
      if (mCap != mLast) begin
        mSnap = mCap;
        mLeft = 7;
      end
    end else begin
      mLeft = mLeft - 1;
      if (mLeft == 0) begin
        mLast = mSnap;
        mOnes = mSnap % 10;
        mTens = mSnap / 10;
        mDone = 1'b1;
      end
    end
    if (mErrCap != 0) mLatch = 1;
    else if (errClr) mLatch = 0;
    mErrCap = int'(errIn);
    mCap = int'(result);
  endtask

  task automatic checkOutput(input string tag);
    total++;
    assert (an === eAn) else begin
      bad++;
      $error("[TB] FAIL %s an: observed=%b expected=%b", tag, an, eAn);
    end
    total++;
    assert (seg === eSeg) else begin
      bad++;
      $error("[TB] FAIL %s seg: observed=%b expected=%b", tag, seg, eSeg);
    end
    total++;
    assert (dp === 1'b1) else begin
      bad++;
      $error("[TB] FAIL %s dp: observed=%b expected=1", tag, dp);
    end
    total++;
    assert (busy === (mLeft != 0)) else begin
      bad++;
      $error("[TB] FAIL %s busy: observed=%b expected=%b", tag, busy, (mLeft != 0));
    end
    total++;
    assert (done === mDone) else begin
      bad++;
      $error("[TB] FAIL %s done: observed=%b expected=%b", tag, done, mDone);
    end
  endtask

  task automatic checkLit(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, predict, clock, sample #1 after the edge.
  task automatic applyStimulus(input logic [5:0] res, input logic e, input logic c,
                               input string tag);
    result = res;
    errIn  = e;
    errClr = c;
    if (rst) modelReset();
    else modelStep();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    int doneAt;
    int doneCnt;
    logic [5:0] r;

    rst = 1'b1; result = '0; errIn = 1'b0; errClr = 1'b0;
    #2;
    modelReset();
    checkOutput("reset");
    checkLit("reset an", 32'(an), 32'h0F);
    checkLit("reset seg", 32'(seg), 32'h7F);
    checkLit("reset busy", 32'(busy), 32'h0);
    checkLit("reset done", 32'(done), 32'h0);
    applyStimulus(6'd0, 1'b0, 1'b0, "in reset");
    applyStimulus(6'd0, 1'b0, 1'b0, "in reset");

    // Release: first edge lights digit 0 with '0'; result 0 converts nothing.
    rst = 1'b0;
    applyStimulus(6'd0, 1'b0, 1'b0, "release");
    checkLit("first an", 32'(an), 32'b1110);
    checkLit("first seg", 32'(seg), 32'b1000000);
    for (int k = 0; k < 4; k++) applyStimulus(6'd0, 1'b0, 1'b0, "scan");
    checkLit("idx1 an", 32'(an), 32'b1101);
    checkLit("tens blank", 32'(seg), 32'h7F);
    checkLit("no conv busy", 32'(busy), 32'h0);

    // Result 63 held: done exactly 8 edges after the capture edge.
    doneAt = 0;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(6'd63, 1'b0, 1'b0, "r63");
      if (done && doneAt == 0) doneAt = k;
    end
    checkLit("done latency 63", 32'(doneAt), 32'd9);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(6'd63, 1'b0, 1'b0, "r63 scan");
      if (an == 4'b1110) checkLit("ones 3", 32'(seg), 32'b0110000);
      if (an == 4'b1101) checkLit("tens 6", 32'(seg), 32'b0000010);
      if (an[3:2] != 2'b11) checkLit("upper blank", 32'(seg), 32'h7F);
    end

    // Change to 7 during the 63 conversion: two conversions back to back.
    for (int k = 0; k < 12; k++) applyStimulus(6'd10, 1'b0, 1'b0, "settle 10");
    doneCnt = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'd63, 1'b0, 1'b0, "mid 63");
      if (done) doneCnt++;
    end
    for (int k = 0; k < 25; k++) begin
      applyStimulus(6'd7, 1'b0, 1'b0, "mid 7");
      if (done) doneCnt++;
    end
    checkLit("two dones", 32'(doneCnt), 32'd2);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(6'd7, 1'b0, 1'b0, "r7 scan");
      if (an == 4'b1110) checkLit("ones 7", 32'(seg), 32'b1111000);
      if (an == 4'b1101) checkLit("tens blank 7", 32'(seg), 32'h7F);
    end

    // One-cycle error pulse: "-Er-" until cleared.
    applyStimulus(6'd7, 1'b1, 1'b0, "err pulse");
    for (int k = 0; k < 20; k++) begin
      applyStimulus(6'd7, 1'b0, 1'b0, "err show");
      if (k >= 2) begin
        if (an == 4'b1110) checkLit("err idx0", 32'(seg), 32'(DASH));
        if (an == 4'b1101) checkLit("err idx1", 32'(seg), 32'(GR));
        if (an == 4'b1011) checkLit("err idx2", 32'(seg), 32'(GE));
        if (an == 4'b0111) checkLit("err idx3", 32'(seg), 32'(DASH));
      end
    end
    applyStimulus(6'd7, 1'b1, 1'b0, "err again");
    for (int k = 0; k < 3; k++) applyStimulus(6'd7, 1'b1, 1'b1, "err+clr");
    for (int k = 0; k < 8; k++) applyStimulus(6'd7, 1'b0, 1'b0, "err held");
    applyStimulus(6'd7, 1'b0, 1'b1, "clr");
    for (int k = 0; k < 18; k++) begin
      applyStimulus(6'd7, 1'b0, 1'b0, "after clr");
      if (k >= 1 && an == 4'b1110) checkLit("restored 7", 32'(seg), 32'b1111000);
    end

    // Randomised traffic against the model.
    r = 6'd7;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) r = 6'($urandom_range(0, 63));
      applyStimulus(r, ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0), "random");
    end

    // Reset in the middle of converting 45.
    for (int k = 0; k < 12; k++) applyStimulus(6'd0, 1'b0, 1'b1, "settle 0");
    for (int k = 0; k < 5; k++) applyStimulus(6'd45, 1'b0, 1'b0, "conv 45");
    checkLit("busy before reset", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("mid reset");
    checkLit("mid reset an", 32'(an), 32'h0F);
    checkLit("mid reset seg", 32'(seg), 32'h7F);
    checkLit("mid reset busy", 32'(busy), 32'h0);
    doneCnt = 0;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(6'd45, 1'b0, 1'b0, "held reset");
      if (done) doneCnt++;
    end
    checkLit("no done in reset", 32'(doneCnt), 32'd0);
    rst = 1'b0;
    applyStimulus(6'd45, 1'b0, 1'b0, "release 45");
    checkLit("shows 0", 32'(seg), 32'b1000000);
    for (int k = 2; k <= 24; k++) begin
      applyStimulus(6'd45, 1'b0, 1'b0, "r45");
      if (done) doneCnt++;
      if (k > 12 && an == 4'b1110) checkLit("ones 5", 32'(seg), 32'b0010010);
      if (k > 12 && an == 4'b1101) checkLit("tens 4", 32'(seg), 32'b0011001);
    end
    checkLit("one done 45", 32'(doneCnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
